// File: rtl/shift_add_multiplier_if.sv
// Operand/result bundle for the sequential mantissa multiplier.
// master drives start/operands; slave (the multiplier) returns product/status.
interface shift_add_multiplier_if #(
  parameter int WIDTH = 24
);
  logic               i_start;
  logic [WIDTH-1:0]   i_mult1;
  logic [WIDTH-1:0]   i_mult2;
  logic [2*WIDTH-1:0] o_product;
  logic               o_busy;
  logic               o_done;

  modport master (output i_start, i_mult1, i_mult2,
                  input  o_product, o_busy, o_done);
  modport slave  (input  i_start, i_mult1, i_mult2,
                  output o_product, o_busy, o_done);
endinterface

// File: rtl/shift_add_multiplier.sv
// Radix-2 shift-and-add unsigned multiplier for the mantissa path.
// One WIDTH-bit ripple adder is reused over WIDTH iterations; the product
// is delivered to the normalise/round stage with a one-cycle done pulse.

// Single-bit full adder cell, replicated along the ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// WIDTH-bit ripple-carry adder built from an array of full_adder cells.
module ripple_adder #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co
);
  logic [WIDTH:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a (a[i]),
      .b (b[i]),
      .ci(c[i]),
      .s (s[i]),
      .co(c[i+1])
    );
  end

  assign co = c[WIDTH];
endmodule

module shift_add_multiplier #(
  parameter int WIDTH = 24
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  shift_add_multiplier_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   m_q;      // multiplicand
  logic [WIDTH-1:0]   h_q;      // upper accumulator half
  logic [WIDTH-1:0]   l_q;      // lower half; holds unconsumed multiplier bits
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] prod_q;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               co;
  logic [2*WIDTH-1:0] acc_shift;
  logic               accept;
  logic               last;

  // A zero addend turns the add into a pass-through of H when L[0] is clear.
  assign addend = l_q[0] ? m_q : '0;

  ripple_adder #(.WIDTH(WIDTH)) u_add (
    .a (h_q),
    .b (addend),
    .ci(1'b0),
    .s (sum),
    .co(co)
  );

  // Carry lands in the top bit, so the full (2^W-1)^2 range never overflows.
  assign acc_shift = {co, sum, l_q[WIDTH-1:1]};
  assign accept    = bus.i_start && (state == IDLE || state == DONE);
  assign last      = (cnt_q == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state: DONE re-accepts a start so operations can run back-to-back.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_start) state_nxt = RUN;
      RUN:     if (last)        state_nxt = DONE;
      DONE:    state_nxt = bus.i_start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, add-and-shift while running.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_q    <= '0;
      h_q    <= '0;
      l_q    <= '0;
      cnt_q  <= '0;
      prod_q <= '0;
    end else if (accept) begin
      m_q   <= bus.i_mult1;
      l_q   <= bus.i_mult2;
      h_q   <= '0;
      cnt_q <= '0;
    end else if (state == RUN) begin
      {h_q, l_q} <= acc_shift;
      cnt_q      <= cnt_q + CW'(1);
      if (last) prod_q <= acc_shift;
    end
  end

  assign bus.o_product = prod_q;
  assign bus.o_busy    = (state == RUN);
  assign bus.o_done    = (state == DONE);
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier at WIDTH=8 and WIDTH=24.
// The driver predicts acceptance from timing alone and queues a*b with the
// cycle its done pulse is due; per-DUT monitors check every cycle.
module tb_shift_add_multiplier;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shift_add_multiplier_if #(.WIDTH(8))  if8();
  shift_add_multiplier_if #(.WIDTH(24)) if24();

  shift_add_multiplier #(.WIDTH(8))  u8  (.i_clk(clk), .i_rst_n(rst_n), .bus(if8));
  shift_add_multiplier #(.WIDTH(24)) u24 (.i_clk(clk), .i_rst_n(rst_n), .bus(if24));

  typedef struct {
    logic [63:0] prod;
    int          done_cyc;
  } exp_t;

  exp_t        q8[$];
  exp_t        q24[$];
  logic [63:0] last8  = '0;
  logic [63:0] last24 = '0;
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;
  bit          has[2];
  int          last_acc[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] rop(input int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return mask;
      default: return {32'd0, $urandom} & mask;
    endcase
  endfunction

  // One driven cycle on DUT d. A start is taken only when no operation is
  // in flight, i.e. at least w+1 edges after the previous acceptance.
  task automatic step(input int d, input bit s, input logic [63:0] a, input logic [63:0] b);
    int          w, e;
    bit          acc;
    logic [63:0] mask;
    w    = (d == 0) ? 8 : 24;
    mask = (64'd1 << w) - 64'd1;
    @(negedge clk);
    if (d == 0) begin
      if8.i_start = s; if8.i_mult1 = a[7:0]; if8.i_mult2 = b[7:0];
    end else begin
      if24.i_start = s; if24.i_mult1 = a[23:0]; if24.i_mult2 = b[23:0];
    end
    e   = cyc + 1;
    acc = s && (!has[d] || e >= last_acc[d] + w + 1);
    @(posedge clk);
    #1;
    if (acc) begin
      has[d]      = 1'b1;
      last_acc[d] = e;
      if (d == 0) q8.push_back('{prod: (a & mask) * (b & mask), done_cyc: e + w});
      else        q24.push_back('{prod: (a & mask) * (b & mask), done_cyc: e + w});
    end
  endtask

  task automatic op(input int d, input logic [63:0] a, input logic [63:0] b);
    step(d, 1'b1, a, b);
    repeat (((d == 0) ? 8 : 24) + 1) step(d, 1'b0, '0, '0);
  endtask

  // Monitor for the 8-bit DUT.
  always @(negedge clk) begin
    automatic bit ed = (q8.size() > 0) && (cyc == q8[0].done_cyc);
    automatic bit eb = (q8.size() > 0) && (cyc <  q8[0].done_cyc);
    chk("done8", 64'(if8.o_done), 64'(ed));
    chk("busy8", 64'(if8.o_busy), 64'(eb));
    if (!rst_n) begin
      chk("rst_prod8", 64'(if8.o_product), '0);
      last8 <= '0;
    end else if (ed) begin
      chk("prod8", 64'(if8.o_product), q8[0].prod);
      last8 <= q8[0].prod;
      void'(q8.pop_front());
    end else begin
      chk("hold8", 64'(if8.o_product), last8);
    end
  end

  // Monitor for the 24-bit DUT.
  always @(negedge clk) begin
    automatic bit ed = (q24.size() > 0) && (cyc == q24[0].done_cyc);
    automatic bit eb = (q24.size() > 0) && (cyc <  q24[0].done_cyc);
    chk("done24", 64'(if24.o_done), 64'(ed));
    chk("busy24", 64'(if24.o_busy), 64'(eb));
    if (!rst_n) begin
      chk("rst_prod24", 64'(if24.o_product), '0);
      last24 <= '0;
    end else if (ed) begin
      chk("prod24", 64'(if24.o_product), q24[0].prod);
      last24 <= q24[0].prod;
      void'(q24.pop_front());
    end else begin
      chk("hold24", 64'(if24.o_product), last24);
    end
  end

  initial begin
    if8.i_start  = 1'b0; if8.i_mult1  = '0; if8.i_mult2  = '0;
    if24.i_start = 1'b0; if24.i_mult1 = '0; if24.i_mult2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed operands.
    op(0, 64'h0D, 64'h0B);
    op(0, 64'hFF, 64'hFF);
    op(0, 64'h00, 64'hA5);
    op(1, 64'h800000, 64'hC00000);
    op(1, 64'hFFFFFF, 64'hFFFFFF);

    // Start held high with fresh operands every cycle: one result per 9.
    for (int i = 0; i < 45; i++) step(0, 1'b1, rop(8), rop(8));
    repeat (10) step(0, 1'b0, '0, '0);

    // Abort during the fourth RUN cycle, then a clean 3x5.
    step(0, 1'b1, 64'hC3, 64'h5A);
    repeat (3) step(0, 1'b0, '0, '0);
    #1;
    rst_n = 1'b0;
    q8.delete();
    has[0] = 1'b0;
    has[1] = 1'b0;
    #1;
    chk("abort_busy", 64'(if8.o_busy), '0);
    chk("abort_done", 64'(if8.o_done), '0);
    chk("abort_prod", 64'(if8.o_product), '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    op(0, 64'd3, 64'd5);

    // Random regression on both widths, with stray starts while busy.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          step(0, 1'b1, rop(8), rop(8));
          repeat (8 + $urandom_range(0, 2))
            step(0, $urandom_range(0, 4) == 0, rop(8), rop(8));
        end
      end
      begin
        for (int i = 0; i < 150; i++) begin
          step(1, 1'b1, rop(24), rop(24));
          repeat (24 + $urandom_range(0, 2))
            step(1, $urandom_range(0, 4) == 0, rop(24), rop(24));
        end
      end
    join
    if8.i_start  = 1'b0;
    if24.i_start = 1'b0;

    for (int i = 0; i < 60 && (q8.size() != 0 || q24.size() != 0); i++) @(negedge clk);
    chk("drain8",  64'(q8.size()),  '0);
    chk("drain24", 64'(q24.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
